// File: rtl/fetch_stage_pkg.sv
// Shared types for the instruction fetch stage and its consumers.
// Holds the IF/ID bundle, instruction type and PC helpers.
package fetch_stage_pkg;

    localparam int PC_WIDTH = 32;

    typedef logic [31:0]         instruction_type;
    typedef logic [PC_WIDTH-1:0] pc_type;

    localparam instruction_type NOP_INSTRUCTION = 32'h0000_0013;
    localparam pc_type          PC_STEP         = pc_type'(4);

    typedef struct packed {
        logic            valid;
        pc_type          pc;
        instruction_type instruction;
    } if_id_type;

    typedef enum logic {
        ST_FETCH = 1'b0,
        ST_HOLD  = 1'b1
    } fetch_state_e;

    function automatic pc_type align_pc(input pc_type a);
        return {a[PC_WIDTH-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry {pc, instruction} store that catches a fetch response
// arriving while decode is stalled.
module fetch_skid_buffer
    import fetch_stage_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            load_i,
    input  logic            drain_i,
    input  logic            clear_i,
    input  pc_type          pc_i,
    input  instruction_type instr_i,
    output logic            valid_o,
    output pc_type          pc_o,
    output instruction_type instr_o
);

    logic            valid_q;
    pc_type          pc_q;
    instruction_type instr_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            instr_q <= '0;
        end else if (clear_i) begin
            valid_q <= 1'b0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            pc_q    <= pc_i;
            instr_q <= instr_i;
        end else if (drain_i) begin
            valid_q <= 1'b0;
        end
    end

    assign valid_o = valid_q;
    assign pc_o    = pc_q;
    assign instr_o = instr_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, one-cycle imem requests, IF/ID register
// and a skid entry so no instruction is lost or duplicated under stall.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter pc_type RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            redirect,
    input  logic [31:0]     redirect_pc,
    output logic            imem_req,
    output logic [31:0]     imem_addr,
    input  logic [31:0]     imem_rdata,
    output logic            if_valid,
    output logic [31:0]     if_pc,
    output instruction_type if_instruction
);

    pc_type          pc_q;
    logic            inflight_q;
    pc_type          inflight_pc_q;
    if_id_type       if_id_q;

    logic            skid_valid;
    pc_type          skid_pc;
    instruction_type skid_instr;
    logic            skid_load;
    logic            skid_drain;
    fetch_state_e    state;

    // The skid valid bit is the FSM state: empty = FETCH, full = HOLD.
    assign state = skid_valid ? ST_HOLD : ST_FETCH;

    assign imem_req  = rst && !stall && !redirect;
    assign imem_addr = pc_q;

    assign skid_load  = !redirect && state == ST_FETCH
                        && stall && inflight_q;
    assign skid_drain = !redirect && state == ST_HOLD && !stall;

    fetch_skid_buffer u_skid (
        .clk     (clk),
        .rst     (rst),
        .load_i  (skid_load),
        .drain_i (skid_drain),
        .clear_i (redirect),
        .pc_i    (inflight_pc_q),
        .instr_i (imem_rdata),
        .valid_o (skid_valid),
        .pc_o    (skid_pc),
        .instr_o (skid_instr)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q          <= align_pc(RESET_PC);
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else if (redirect) begin
            pc_q       <= align_pc(redirect_pc);
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= imem_req;
            if (imem_req) begin
                pc_q          <= pc_q + PC_STEP;
                inflight_pc_q <= pc_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            if_id_q <= '0;
        end else if (redirect) begin
            if_id_q.valid <= 1'b0;
        end else begin
            unique case (state)
                ST_FETCH: begin
                    if (!stall) begin
                        if (inflight_q) begin
                            if_id_q <= '{valid: 1'b1,
                                         pc: inflight_pc_q,
                                         instruction: imem_rdata};
                        end else begin
                            if_id_q.valid <= 1'b0;
                        end
                    end
                end
                ST_HOLD: begin
                    if (!stall) begin
                        if_id_q <= '{valid: 1'b1,
                                     pc: skid_pc,
                                     instruction: skid_instr};
                    end
                end
                default: ;
            endcase
        end
    end

    assign if_valid       = if_id_q.valid;
    assign if_pc          = if_id_q.pc;
    assign if_instruction = if_id_q.instruction;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: reset, streaming, stall/skid,
// redirect, PC wrap and asynchronous reset mid-stream.
module tb_fetch_stage;
    import fetch_stage_pkg::*;

    localparam logic [31:0] K = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instruction;

    logic        hi_stall = 1'b0;
    logic        hi_redirect = 1'b0;
    logic [31:0] hi_redirect_pc = 32'h0;
    logic        hi_req;
    logic [31:0] hi_addr;
    logic [31:0] hi_rdata;
    logic        hi_valid;
    logic [31:0] hi_pc;
    logic [31:0] hi_instr;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .if_instruction (if_instruction)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) dut_hi (
        .clk            (clk),
        .rst            (rst),
        .stall          (hi_stall),
        .redirect       (hi_redirect),
        .redirect_pc    (hi_redirect_pc),
        .imem_req       (hi_req),
        .imem_addr      (hi_addr),
        .imem_rdata     (hi_rdata),
        .if_valid       (hi_valid),
        .if_pc          (hi_pc),
        .if_instruction (hi_instr)
    );

    // One-cycle memory; junk when no request so stale data is visible.
    always @(posedge clk) begin
        imem_rdata <= imem_req ? (imem_addr ^ K) : 32'hDEAD_BEEF;
        hi_rdata   <= hi_req ? (hi_addr ^ K) : 32'hDEAD_BEEF;
    end

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic next(input logic r, input logic s,
                        input logic rd, input logic [31:0] rp);
        @(posedge clk);
        #1;
        rst = r;
        stall = s;
        redirect = rd;
        redirect_pc = rp;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b0;
        stall = 1'b0;
        redirect = 1'b0;
        redirect_pc = 32'h0;
        @(negedge clk);
        check("rst valid", 32'(if_valid), 32'd0);
        check("rst pc", if_pc, 32'h0);
        check("rst instr", if_instruction, 32'h0);
        check("rst req", 32'(imem_req), 32'd0);
        check("rst addr", imem_addr, 32'h0);

        next(1, 0, 0, 0); // c0
        check("c0 req", 32'(imem_req), 32'd1);
        check("c0 addr", imem_addr, 32'h0);
        check("c0 hi addr", hi_addr, 32'hFFFF_FFF8);
        next(1, 0, 0, 0); // c1
        check("c1 valid", 32'(if_valid), 32'd0);
        check("c1 addr", imem_addr, 32'h4);
        next(1, 0, 0, 0); // c2
        check("c2 valid", 32'(if_valid), 32'd1);
        check("c2 pc", if_pc, 32'h0);
        check("c2 instr", if_instruction, K);
        check("c2 hi pc", hi_pc, 32'hFFFF_FFF8);
        check("c2 hi addr wrap", hi_addr, 32'h0);

        next(1, 1, 0, 0); // c3: stall while 0x8 in flight
        check("c3 pc", if_pc, 32'h4);
        check("c3 req", 32'(imem_req), 32'd0);
        check("c3 hi pc", hi_pc, 32'hFFFF_FFFC);
        next(1, 1, 0, 0); // c4
        check("c4 pc", if_pc, 32'h4);
        check("c4 req", 32'(imem_req), 32'd0);
        check("c4 hi pc wrap", hi_pc, 32'h0);
        check("c4 hi instr", hi_instr, K);
        next(1, 1, 0, 0); // c5
        check("c5 pc", if_pc, 32'h4);
        check("c5 req", 32'(imem_req), 32'd0);
        next(1, 0, 0, 0); // c6: release
        check("c6 pc", if_pc, 32'h4);
        check("c6 req", 32'(imem_req), 32'd1);
        check("c6 addr", imem_addr, 32'hC);
        next(1, 0, 0, 0); // c7
        check("c7 pc skid", if_pc, 32'h8);
        check("c7 instr skid", if_instruction, 32'hA5A5_0008);
        next(1, 0, 0, 0); // c8
        check("c8 pc", if_pc, 32'hC);
        check("c8 valid", 32'(if_valid), 32'd1);

        next(1, 1, 0, 0); // c9: 0x14 into skid
        check("c9 pc", if_pc, 32'h10);
        next(1, 1, 1, 32'h100); // c10: redirect, skid full
        check("c10 req", 32'(imem_req), 32'd0);
        next(1, 0, 0, 0); // c11
        check("c11 valid", 32'(if_valid), 32'd0);
        check("c11 req", 32'(imem_req), 32'd1);
        check("c11 addr", imem_addr, 32'h100);
        next(1, 0, 0, 0); // c12
        check("c12 valid", 32'(if_valid), 32'd0);
        next(1, 0, 0, 0); // c13
        check("c13 valid", 32'(if_valid), 32'd1);
        check("c13 pc", if_pc, 32'h100);
        check("c13 instr", if_instruction, 32'hA5A5_0100);
        next(1, 0, 0, 0); // c14
        check("c14 pc", if_pc, 32'h104);

        next(1, 0, 1, 32'h0000_0203); // c15: misaligned redirect
        check("c15 req", 32'(imem_req), 32'd0);
        next(1, 0, 0, 0); // c16
        check("c16 addr align", imem_addr, 32'h200);
        check("c16 valid", 32'(if_valid), 32'd0);
        next(1, 0, 0, 0); // c17
        check("c17 valid", 32'(if_valid), 32'd0);
        next(1, 0, 0, 0); // c18
        check("c18 valid", 32'(if_valid), 32'd1);
        check("c18 pc", if_pc, 32'h200);

        next(1, 1, 0, 0); // c19: 0x208 into skid
        check("c19 pc", if_pc, 32'h204);
        next(1, 1, 0, 0); // c20
        check("c20 valid", 32'(if_valid), 32'd1);
        #1;
        rst = 1'b0;
        #1;
        check("arst valid", 32'(if_valid), 32'd0);
        check("arst pc", if_pc, 32'h0);
        check("arst instr", if_instruction, 32'h0);
        check("arst req", 32'(imem_req), 32'd0);
        check("arst addr", imem_addr, 32'h0);

        next(1, 0, 0, 0); // d0
        check("d0 req", 32'(imem_req), 32'd1);
        check("d0 addr", imem_addr, 32'h0);
        next(1, 0, 0, 0); // d1
        check("d1 valid", 32'(if_valid), 32'd0);
        next(1, 0, 0, 0); // d2
        check("d2 valid", 32'(if_valid), 32'd1);
        check("d2 pc", if_pc, 32'h0);
        check("d2 instr", if_instruction, K);
        next(1, 0, 0, 0); // d3
        check("d3 pc", if_pc, 32'h4);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
